// File: rtl/vq_compress_sequencer.sv
// vq_compress_sequencer
//
// Frame sequencer for the 64-entry VEP array and its winner-select comparator.
// A frame runs a fixed schedule:
//   LOAD_W : issue 64 weight reads (RAM_W_A = 0..63), then one drain cycle so
//            the last weight can be loaded.
//   STREAM : issue one pixel read per clock (RAM_IF_A = 0..PIXELS-1).
//   FLUSH  : two cycles to drain the 2-stage pixel pipeline.
//   DONE   : frame complete; waits for the next start.
// The pixel address travels down a 2-stage valid pipeline:
//   stage 1: RAM_IF_Q is valid, so all VEPs are enabled;
//   stage 2: the comparator's winner is valid and is written to RAM_TAG.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a frame (accepted in IDLE or DONE only)
//   busy, done            : frame handshake
//   RAM_W_*               : weight RAM port (read only)
//   RAM_IF_*              : image RAM port (read only)
//   RAM_TAG_*             : tag RAM port (write only)
//   vep_weight_en         : one-hot weight load strobe per VEP
//   vep_pixel_en          : all-ones while RAM_IF_Q holds a valid pixel
//   winner_x, winner_y    : combinational winner coordinates from the comparator
module vq_compress_sequencer #(
  parameter int unsigned PIXELS = 65536,
  parameter int unsigned AW     = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,

  output logic          RAM_W_OE,
  output logic          RAM_W_WE,
  output logic [AW-1:0] RAM_W_A,
  output logic [23:0]   RAM_W_D,

  output logic          RAM_IF_OE,
  output logic          RAM_IF_WE,
  output logic [AW-1:0] RAM_IF_A,
  output logic [23:0]   RAM_IF_D,

  output logic          RAM_TAG_OE,
  output logic          RAM_TAG_WE,
  output logic [AW-1:0] RAM_TAG_A,
  output logic [23:0]   RAM_TAG_D,

  output logic [63:0]   vep_weight_en,
  output logic [63:0]   vep_pixel_en,
  input  logic [2:0]    winner_x,
  input  logic [2:0]    winner_y
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoadW  = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StFlush  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // One bit wider than the address so PIXELS = 2^AW ends without wrapping.
  localparam logic [AW:0] PixLast = (AW+1)'(PIXELS - 1);
  localparam logic [AW:0] PixOne  = (AW+1)'(1);

  logic [2:0]    state_q, state_d;
  logic [6:0]    k_q, k_d;          // 0..63 issue, 64 = drain cycle
  logic [AW:0]   p_q, p_d;
  logic          flush_q, flush_d;

  // Weight load pipeline: address issued last cycle -> load strobe now.
  logic          wv_q;
  logic [5:0]    wk_q;

  // Pixel address pipeline.
  logic          s1_v_q, s2_v_q;
  logic [AW-1:0] s1_p_q, s2_p_q;

  logic          w_issue;
  logic          p_issue;

  assign w_issue = (state_q == StLoadW) && !k_q[6];
  assign p_issue = (state_q == StStream);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    flush_d = flush_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoadW;
          k_d     = 7'd0;
        end
      end
      StLoadW: begin
        if (k_q[6]) begin
          state_d = StStream;
          p_d     = '0;
        end else begin
          k_d = k_q + 7'd1;
        end
      end
      StStream: begin
        if (p_q == PixLast) begin
          state_d = StFlush;
          flush_d = 1'b0;
        end else begin
          p_d = p_q + PixOne;
        end
      end
      StFlush: begin
        if (flush_q) begin
          state_d = StDone;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 7'd0;
      p_q     <= '0;
      flush_q <= 1'b0;
      wv_q    <= 1'b0;
      wk_q    <= 6'd0;
      s1_v_q  <= 1'b0;
      s1_p_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_p_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      flush_q <= flush_d;
      wv_q    <= w_issue;
      wk_q    <= k_q[5:0];
      s1_v_q  <= p_issue;
      s1_p_q  <= p_q[AW-1:0];
      s2_v_q  <= s1_v_q;
      s2_p_q  <= s1_p_q;
    end
  end

  always_comb begin
    busy = (state_q == StLoadW) || (state_q == StStream) || (state_q == StFlush);
    done = (state_q == StDone);

    RAM_W_OE = w_issue;
    RAM_W_WE = 1'b0;
    RAM_W_A  = w_issue ? AW'(k_q[5:0]) : '0;
    RAM_W_D  = 24'd0;

    RAM_IF_OE = p_issue;
    RAM_IF_WE = 1'b0;
    RAM_IF_A  = p_issue ? p_q[AW-1:0] : '0;
    RAM_IF_D  = 24'd0;

    RAM_TAG_OE = 1'b0;
    RAM_TAG_WE = s2_v_q;
    RAM_TAG_A  = s2_v_q ? s2_p_q : '0;
    RAM_TAG_D  = s2_v_q ? {18'd0, winner_y, winner_x} : 24'd0;

    vep_weight_en = wv_q ? (64'd1 << wk_q) : 64'd0;
    vep_pixel_en  = s1_v_q ? {64{1'b1}} : 64'd0;
  end

endmodule

// File: tb/tb_vq_compress_sequencer.sv
module tb_vq_compress_sequencer;

  typedef struct packed {
    logic        w_oe;
    logic        w_we;
    logic [17:0] w_a;
    logic [23:0] w_d;
    logic        if_oe;
    logic        if_we;
    logic [17:0] if_a;
    logic [23:0] if_d;
    logic        t_oe;
    logic        t_we;
    logic [17:0] t_a;
    logic [23:0] t_d;
    logic [63:0] wen;
    logic [63:0] pen;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;

  obs_t oa, ob;
  logic [2:0]  wx_a, wy_a, wx_b, wy_b;
  logic [17:0] a1_a, a2_a, a1_b, a2_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vq_compress_sequencer #(.PIXELS(8), .AW(18)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .start         (start_a),
    .busy          (oa.busy),
    .done          (oa.done),
    .RAM_W_OE      (oa.w_oe),
    .RAM_W_WE      (oa.w_we),
    .RAM_W_A       (oa.w_a),
    .RAM_W_D       (oa.w_d),
    .RAM_IF_OE     (oa.if_oe),
    .RAM_IF_WE     (oa.if_we),
    .RAM_IF_A      (oa.if_a),
    .RAM_IF_D      (oa.if_d),
    .RAM_TAG_OE    (oa.t_oe),
    .RAM_TAG_WE    (oa.t_we),
    .RAM_TAG_A     (oa.t_a),
    .RAM_TAG_D     (oa.t_d),
    .vep_weight_en (oa.wen),
    .vep_pixel_en  (oa.pen),
    .winner_x      (wx_a),
    .winner_y      (wy_a)
  );

  vq_compress_sequencer #(.PIXELS(1), .AW(18)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .start         (start_b),
    .busy          (ob.busy),
    .done          (ob.done),
    .RAM_W_OE      (ob.w_oe),
    .RAM_W_WE      (ob.w_we),
    .RAM_W_A       (ob.w_a),
    .RAM_W_D       (ob.w_d),
    .RAM_IF_OE     (ob.if_oe),
    .RAM_IF_WE     (ob.if_we),
    .RAM_IF_A      (ob.if_a),
    .RAM_IF_D      (ob.if_d),
    .RAM_TAG_OE    (ob.t_oe),
    .RAM_TAG_WE    (ob.t_we),
    .RAM_TAG_A     (ob.t_a),
    .RAM_TAG_D     (ob.t_d),
    .vep_weight_en (ob.wen),
    .vep_pixel_en  (ob.pen),
    .winner_x      (wx_b),
    .winner_y      (wy_b)
  );

  // Comparator model: winner for pixel p is x = p[2:0], y = 7 - p[2:0],
  // presented two cycles after the pixel address was issued.
  always @(posedge clk) begin
    a1_a <= oa.if_a;
    a2_a <= a1_a;
    a1_b <= ob.if_a;
    a2_b <= a1_b;
  end
  assign wx_a = a2_a[2:0];
  assign wy_a = 3'd7 - a2_a[2:0];
  assign wx_b = a2_b[2:0];
  assign wy_b = 3'd7 - a2_b[2:0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=S+%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // Expected outputs at cycle S+n of a frame; n = 0 means idle/reset (all zero).
  task automatic check_cycle(input bit b, input int pix, input int n);
    obs_t        o;
    logic [63:0] one;
    logic [63:0] e_wen;
    logic [17:0] a;
    logic [2:0]  ax;
    logic        in_w, in_if, in_pen, in_tag;
    o      = b ? ob : oa;
    one    = 64'd1;
    in_w   = (n >= 1) && (n <= 64);
    in_if  = (n >= 66) && (n <= 65 + pix);
    in_pen = (n >= 67) && (n <= 66 + pix);
    in_tag = (n >= 68) && (n <= 67 + pix);
    e_wen  = ((n >= 2) && (n <= 65)) ? (one << (n - 2)) : 64'd0;
    a      = 18'(n - 68);
    ax     = a[2:0];
    chk("w_oe", n, 64'(o.w_oe), 64'(in_w));
    chk("w_a", n, 64'(o.w_a), in_w ? 64'(n - 1) : 64'd0);
    chk("w_we", n, 64'(o.w_we), 64'd0);
    chk("w_d", n, 64'(o.w_d), 64'd0);
    chk("if_oe", n, 64'(o.if_oe), 64'(in_if));
    chk("if_a", n, 64'(o.if_a), in_if ? 64'(n - 66) : 64'd0);
    chk("if_we", n, 64'(o.if_we), 64'd0);
    chk("if_d", n, 64'(o.if_d), 64'd0);
    chk("tag_oe", n, 64'(o.t_oe), 64'd0);
    chk("tag_we", n, 64'(o.t_we), 64'(in_tag));
    chk("tag_a", n, 64'(o.t_a), in_tag ? 64'(a) : 64'd0);
    chk("tag_d", n, 64'(o.t_d), in_tag ? 64'({3'd7 - ax, ax}) : 64'd0);
    chk("weight_en", n, o.wen, e_wen);
    chk("pixel_en", n, o.pen, in_pen ? {64{1'b1}} : 64'd0);
    chk("busy", n, 64'(o.busy), 64'((n >= 1) && (n <= 67 + pix)));
    chk("done", n, 64'(o.done), 64'(n >= 68 + pix));
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset: everything stays zero.
    for (int i = 0; i < 20; i++) begin
      check_cycle(1'b0, 8, 0);
      check_cycle(1'b1, 1, 0);
      step();
    end

    // Frame 1: single start pulse.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      check_cycle(1'b0, 8, n);
      if (n == 73) begin
        chk("tag5_addr", n, 64'(oa.t_a), 64'd5);
        chk("tag5_data", n, 64'(oa.t_d), 64'h15);
      end
      step();
    end

    // Frame 2: restart from DONE, with an ignored start pulse at S+30.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      check_cycle(1'b0, 8, n);
      start_a = (n == 30);
      step();
    end
    start_a = 1'b0;

    // Frame 3: reset asserted during S+70 aborts the frame.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      check_cycle(1'b0, 8, n);
      if (n == 70) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_cycle(1'b0, 8, 0);
      step();
    end

    // Frame 4: clean full frame after the abort.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      check_cycle(1'b0, 8, n);
      step();
    end

    // PIXELS = 1 with start held high: frames every 69 cycles, done high one
    // cycle between them.
    start_b = 1'b1;
    step();
    for (int t = 1; t <= 3 * 69; t++) begin
      check_cycle(1'b1, 1, ((t - 1) % 69) + 1);
      step();
    end
    start_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
